// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and constants for the MEM/WB stage.
//   WORD_W / REG_W     : datapath word and register-number widths
//   ACK_TIMEOUT_DEF    : default number of dmem wait cycles before abort
//   TO_CNT_W           : width of the wait counter (ACK_TIMEOUT <= 255)
//   mwb_state_e        : IDLE / ACCESS / DONE
//   m_entry_t          : contents of the M pipeline register
package mem_wb_pkg;
    localparam int WORD_W          = 32;
    localparam int REG_W           = 5;
    localparam int ACK_TIMEOUT_DEF = 16;
    localparam int TO_CNT_W        = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regn_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mwb_state_e;

    typedef struct packed {
        logic  valid;
        logic  regwr;
        logic  memrd;
        logic  memwr;
        regn_t rw;
        word_t alu;
        word_t b;
    } m_entry_t;
endpackage

// File: rtl/mem_wb_timeout.sv
// mem_wb_timeout: counts cycles a dmem request waits for its ack.
//   clk, rst_n : clock, synchronous active-low reset
//   i_start    : first cycle of a new request (count restarts from zero)
//   i_wait     : request outstanding and not acked this cycle
//   o_expired  : this is waiting cycle number ACK_TIMEOUT (abort now)
module mem_wb_timeout
    import mem_wb_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_wait,
    output logic o_expired
);
    localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(ACK_TIMEOUT - 1);

    logic [TO_CNT_W-1:0] r_cnt;
    logic [TO_CNT_W-1:0] w_cnt;

    // The start cycle counts as wait cycle zero regardless of any stale count.
    assign w_cnt     = i_start ? '0 : r_cnt;
    assign o_expired = i_wait && (w_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_start || i_wait)
            r_cnt <= w_cnt + TO_CNT_W'(i_wait);
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M pipeline register, data-memory handshake and W write port.
//   clk, rst_n                 : clock, synchronous active-low reset
//   validE/ALUOutE/bE/rwE/...E : EX result and controls, held while stallM=1
//   stallM                     : a load/store in M is waiting for dmem_ack
//   dmem_req/we/addr/wdata     : data-memory request, held until ack
//   dmem_ack/dmem_rdata        : response, rdata valid in the ack cycle
//   RegWriteW/rwW/ResultW      : register-file write port (registered)
//   fwdValidM/fwdRwM/fwdValM   : forwarding source for EX (non-memory ops only)
//   memErr                     : one-cycle pulse on an aborted access
// Build option MEM_ALIGN_CHECK_EN: a load/store with a misaligned address is
// rejected in its first M cycle with memErr and no request.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              validE,
    input  logic [WORD_W-1:0] ALUOutE,
    input  logic [WORD_W-1:0] bE,
    input  logic [REG_W-1:0]  rwE,
    input  logic              RegWriteE,
    input  logic              MemReadE,
    input  logic              MemWriteE,
    output logic              stallM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [WORD_W-1:0] dmem_rdata,
    output logic              RegWriteW,
    output logic [REG_W-1:0]  rwW,
    output logic [WORD_W-1:0] ResultW,
    output logic              fwdValidM,
    output logic [REG_W-1:0]  fwdRwM,
    output logic [WORD_W-1:0] fwdValM,
    output logic              memErr
);
    mwb_state_e r_state, w_next;
    m_entry_t   r_m;
    logic       r_to_err;
    logic       w_memop, w_aluop, w_misalign, w_issue, w_bad, w_ack;
    logic       w_start, w_expired;

    assign w_memop = r_m.valid && (r_m.memrd || r_m.memwr);
    assign w_aluop = r_m.valid && !r_m.memrd && !r_m.memwr;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_memop && (r_m.alu[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // DONE is the writeback cycle of a load; a load/store that entered M
    // behind it waits (stalled, no request) and starts once back in IDLE.
    assign w_issue = w_memop && !w_misalign && (r_state != DONE);
    assign w_bad   = w_misalign && (r_state != DONE);
    // An ack with no request outstanding is ignored.
    assign w_ack   = w_issue && dmem_ack;
    assign w_start = w_issue && (r_state == IDLE);

    mem_wb_timeout #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_wait    (w_issue && !dmem_ack),
        .o_expired (w_expired)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, ACCESS: begin
                if (w_issue) begin
                    if (w_ack)          w_next = r_m.memrd ? DONE : IDLE;
                    else if (w_expired) w_next = IDLE;
                    else                w_next = ACCESS;
                end else begin
                    w_next = IDLE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        dmem_req = w_issue;
        dmem_we  = w_issue && r_m.memwr;
        stallM   = w_memop && !w_bad && !w_ack;
        memErr   = r_to_err || w_bad;
    end

    assign dmem_addr  = r_m.alu;
    assign dmem_wdata = r_m.b;

    assign fwdValidM = w_aluop && r_m.regwr && (r_m.rw != '0);
    assign fwdRwM    = r_m.rw;
    assign fwdValM   = r_m.alu;

    // M register; an aborted access is dropped even though stallM held it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_m <= '0;
        else if (w_expired)
            r_m.valid <= 1'b0;
        else if (!stallM) begin
            if (validE) r_m <= {1'b1, RegWriteE, MemReadE, MemWriteE, rwE, ALUOutE, bE};
            else        r_m.valid <= 1'b0;
        end
    end

    // Timeout error is reported the cycle after the request is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) r_to_err <= 1'b0;
        else        r_to_err <= w_expired;
    end

    // W register: ALU result straight from M, or load data on ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            rwW       <= '0;
            ResultW   <= '0;
        end else if (w_aluop) begin
            RegWriteW <= r_m.regwr && (r_m.rw != '0);
            rwW       <= r_m.rw;
            ResultW   <= r_m.alu;
        end else if (w_ack && r_m.memrd) begin
            RegWriteW <= r_m.regwr && (r_m.rw != '0);
            rwW       <= r_m.rw;
            ResultW   <= dmem_rdata;
        end else begin
            RegWriteW <= 1'b0;
        end
    end
endmodule
